// File: rtl/tt_cpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tt_cpu_mem_arbiter
// Brief    : Shared 128x4 RAM arbiter between a 4-bit CPU bus and a host port,
//            with CPU clock-enable freeze, host holdoff and debug halt/step.
// Revision : 1.0
// ============================================================================
module tt_cpu_mem_arbiter #(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 4,
    parameter int CPU_SLOTS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              cpu_en,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_wcyc,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              dbg_halt,
    input  logic              dbg_step,
    output logic              halted
);

    localparam int c_depth  = 2 ** ADDR_W;
    localparam int c_slot_w = (CPU_SLOTS < 1) ? 1 : $clog2(CPU_SLOTS + 1);
    localparam logic [c_slot_w-1:0] c_slots    = c_slot_w'(CPU_SLOTS);
    localparam logic [c_slot_w-1:0] c_slot_one = c_slot_w'(1);

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_WDATA = 3'd1,
        ST_HOST  = 3'd2,
        ST_HALT  = 3'd3,
        ST_STEP  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_slot_w-1:0]   r_slot_cnt;
    logic [ADDR_W-1:0]     r_waddr;
    logic                  r_ack;
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_host_from_halt;
    logic                  w_latch_waddr;
    logic                  w_host_elig;
    logic                  w_cpu_run;

    logic [DATA_W-1:0]     r_mem [c_depth];

    assign w_cpu_run   = (r_state == ST_RUN) || (r_state == ST_WDATA) || (r_state == ST_STEP);
    assign w_host_elig = host_req && !r_ack;

    assign cpu_en     = w_cpu_run;
    assign halted     = (r_state == ST_HALT);
    assign host_ack   = r_ack;
    assign host_rdata = r_rdata;
    assign cpu_rdata  = r_mem[cpu_addr];

    always_comb begin
        w_state_nxt   = r_state;
        w_latch_waddr = 1'b0;
        case (r_state)
            ST_RUN: begin
                // A write address phase always wins so the data phase follows directly.
                if (cpu_wcyc) begin
                    w_latch_waddr = 1'b1;
                    w_state_nxt   = ST_WDATA;
                end else if (w_host_elig && (r_slot_cnt == '0)) begin
                    w_state_nxt = ST_HOST;
                end else if (dbg_halt) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_WDATA: begin
                w_state_nxt = dbg_halt ? ST_HALT : ST_RUN;
            end
            ST_HOST: begin
                w_state_nxt = (dbg_halt || r_host_from_halt) ? ST_HALT : ST_RUN;
            end
            ST_HALT: begin
                if (w_host_elig) begin
                    w_state_nxt = ST_HOST;
                end else if (dbg_step) begin
                    w_state_nxt = ST_STEP;
                end else if (!dbg_halt) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_STEP: begin
                if (cpu_wcyc) begin
                    w_latch_waddr = 1'b1;
                    w_state_nxt   = ST_WDATA;
                end else begin
                    w_state_nxt = dbg_halt ? ST_HALT : ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_RUN;
            r_slot_cnt       <= '0;
            r_waddr          <= '0;
            r_ack            <= 1'b0;
            r_rdata          <= '0;
            r_host_from_halt <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_ack            <= (r_state == ST_HOST);
            r_host_from_halt <= (r_state == ST_HALT);
            if (w_latch_waddr) begin
                r_waddr <= cpu_addr;
            end
            if (r_state == ST_HOST) begin
                r_slot_cnt <= c_slots;
                if (!host_we) begin
                    r_rdata <= r_mem[host_addr];
                end
            end else if (w_cpu_run && (r_slot_cnt != '0)) begin
                r_slot_cnt <= r_slot_cnt - c_slot_one;
            end
        end
    end

    // Writes are gated by state, which is cleared asynchronously, so a reset drops any pending write.
    always_ff @(posedge clk) begin
        if (r_state == ST_WDATA) begin
            r_mem[r_waddr] <= cpu_addr[DATA_W-1:0];
        end else if ((r_state == ST_HOST) && host_we) begin
            r_mem[host_addr] <= host_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tt_cpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tt_cpu_mem_arbiter
// Brief    : Randomized scoreboard bench for tt_cpu_mem_arbiter with a
//            cycle-level reference model of RAM ownership.
// Revision : 1.0
// ============================================================================
module tb_tt_cpu_mem_arbiter;

    localparam int ADDR_W    = 7;
    localparam int DATA_W    = 4;
    localparam int CPU_SLOTS = 2;
    localparam int DEPTH     = 128;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cpu_en;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic              cpu_wcyc = 1'b0;
    logic [DATA_W-1:0] cpu_rdata;
    logic              host_req = 1'b0;
    logic              host_we = 1'b0;
    logic [ADDR_W-1:0] host_addr = '0;
    logic [DATA_W-1:0] host_wdata = '0;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;
    logic              dbg_halt = 1'b0;
    logic              dbg_step = 1'b0;
    logic              halted;

    tt_cpu_mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .CPU_SLOTS (CPU_SLOTS)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_en     (cpu_en),
        .cpu_addr   (cpu_addr),
        .cpu_wcyc   (cpu_wcyc),
        .cpu_rdata  (cpu_rdata),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .dbg_halt   (dbg_halt),
        .dbg_step   (dbg_step),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the RAM this cycle, plus a plain array for its contents.
    typedef enum int {M_RUN, M_WR, M_HOST, M_HALT, M_STEP} mmode_t;
    mmode_t            m_mode = M_RUN;
    int                m_hold = 0;
    bit                m_ack = 1'b0;
    logic [DATA_W-1:0] m_hrd = '0;
    bit                m_ret_halt = 1'b0;
    logic [ADDR_W-1:0] m_wa = '0;
    logic [DATA_W-1:0] mm [DEPTH];
    bit                known [DEPTH];
    logic [DATA_W-1:0] sb [$];

    int  checks = 0;
    int  fails = 0;
    int  timeouts = 0;
    bit  done = 1'b0;
    bit  en_neg = 1'b1;
    bit  last_adv = 1'b0;
    bit  cpu_auto = 1'b0;
    bit  host_auto = 1'b0;
    bit  dbg_auto = 1'b0;
    int  cpu_ph = 0;

    initial begin : model
        mmode_t nxt;
        bit     elig;
        bit     cpu_moves;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_mode = M_RUN;
                m_hold = 0;
                m_ack  = 1'b0;
                m_hrd  = '0;
                sb.delete();
            end else begin
                elig      = host_req && !m_ack;
                nxt       = m_mode;
                cpu_moves = (m_mode == M_RUN) || (m_mode == M_WR) || (m_mode == M_STEP);
                m_ack     = 1'b0;
                case (m_mode)
                    M_RUN: begin
                        if (cpu_wcyc) begin
                            m_wa = cpu_addr;
                            nxt  = M_WR;
                        end else if (elig && m_hold == 0) begin
                            nxt        = M_HOST;
                            m_ret_halt = 1'b0;
                        end else if (dbg_halt) begin
                            nxt = M_HALT;
                        end
                    end
                    M_WR: begin
                        mm[m_wa]    = cpu_addr[DATA_W-1:0];
                        known[m_wa] = 1'b1;
                        nxt         = dbg_halt ? M_HALT : M_RUN;
                    end
                    M_HOST: begin
                        if (host_we) begin
                            mm[host_addr]    = host_wdata;
                            known[host_addr] = 1'b1;
                        end else begin
                            m_hrd = mm[host_addr];
                        end
                        sb.push_back(m_hrd);
                        m_ack = 1'b1;
                        nxt   = (dbg_halt || m_ret_halt) ? M_HALT : M_RUN;
                    end
                    M_HALT: begin
                        if (elig) begin
                            nxt        = M_HOST;
                            m_ret_halt = 1'b1;
                        end else if (dbg_step) begin
                            nxt = M_STEP;
                        end else if (!dbg_halt) begin
                            nxt = M_RUN;
                        end
                    end
                    default: begin
                        if (cpu_wcyc) begin
                            m_wa = cpu_addr;
                            nxt  = M_WR;
                        end else begin
                            nxt = dbg_halt ? M_HALT : M_RUN;
                        end
                    end
                endcase
                if (m_mode == M_HOST) m_hold = CPU_SLOTS;
                else if (cpu_moves && m_hold > 0) m_hold = m_hold - 1;
                m_mode = nxt;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    initial begin : monitor
        logic [DATA_W-1:0] e;
        forever begin
            @(negedge clk);
            en_neg = cpu_en;
            chk("cpu_en", int'(cpu_en), int'(m_mode == M_RUN || m_mode == M_WR || m_mode == M_STEP));
            chk("halted", int'(halted), int'(m_mode == M_HALT));
            chk("host_ack", int'(host_ack), int'(m_ack));
            chk("host_rdata_hold", int'(host_rdata), int'(m_hrd));
            if (known[cpu_addr]) chk("cpu_rdata", int'(cpu_rdata), int'(mm[cpu_addr]));
            if (host_ack) begin
                chk("sb_depth_at_ack", sb.size(), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("host_rdata_at_ack", int'(host_rdata), int'(e));
                end
            end
            if (done) begin
                chk("wait_timeouts", timeouts, 0);
                chk("sb_leftover", sb.size(), 0);
                $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
                $finish;
            end
        end
    end

    task automatic new_req();
        host_req   = 1'b1;
        host_we    = 1'($urandom % 2);
        host_addr  = 7'($urandom);
        host_wdata = 4'($urandom);
    endtask

    // One clock: the CPU model only moves on edges where cpu_en was high.
    task automatic tick();
        @(posedge clk);
        last_adv = en_neg;
        #1;
        if (!rst_n) begin
            cpu_wcyc = 1'b0;
            cpu_ph   = 0;
        end else begin
            if (cpu_auto && last_adv) begin
                if (cpu_ph == 1) begin
                    cpu_wcyc = 1'b1;
                    cpu_addr = 7'($urandom);
                    cpu_ph   = 2;
                end else if ($urandom % 4 == 0) begin
                    cpu_wcyc = 1'b1;
                    cpu_addr = 7'($urandom);
                    cpu_ph   = 1;
                end else begin
                    cpu_wcyc = 1'b0;
                    cpu_addr = 7'($urandom);
                    cpu_ph   = 0;
                end
            end
            if (host_auto) begin
                if (host_ack) begin
                    if ($urandom % 3 == 0) new_req();
                    else host_req = 1'b0;
                end else if (!host_req && $urandom % 5 == 0) begin
                    new_req();
                end
            end
            if (dbg_auto) begin
                dbg_step = ($urandom % 6 == 0);
                if ($urandom % 50 == 0) dbg_halt = !dbg_halt;
            end
        end
    endtask

    task automatic wait_ack();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!host_ack && n < 40);
        if (!host_ack) timeouts++;
    endtask

    task automatic cpu_advance();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!last_adv && n < 40);
        if (!last_adv) timeouts++;
    endtask

    task automatic host_xfer(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = a;
        host_wdata = d;
        wait_ack();
        host_req = 1'b0;
    endtask

    initial begin : stim
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        for (int a = 0; a < DEPTH; a++) host_xfer(1'b1, 7'(a), 4'(a * 5 + 3));
        repeat (4) tick();

        host_xfer(1'b1, 7'h10, 4'h5);
        cpu_addr = 7'h10;
        repeat (6) tick();

        // Host read of the same word arrives during the CPU write address phase.
        cpu_addr   = 7'h22;
        cpu_wcyc   = 1'b1;
        host_req   = 1'b1;
        host_we    = 1'b0;
        host_addr  = 7'h22;
        cpu_advance();
        cpu_addr = 7'h0A;
        cpu_advance();
        cpu_wcyc = 1'b0;
        cpu_addr = 7'h22;
        wait_ack();
        host_addr = 7'h05;
        wait_ack();
        host_addr = 7'h06;
        wait_ack();
        host_req = 1'b0;
        repeat (4) tick();

        dbg_halt = 1'b1;
        repeat (3) tick();
        cpu_wcyc = 1'b0;
        dbg_step = 1'b1;
        tick();
        dbg_step = 1'b0;
        repeat (3) tick();
        cpu_addr = 7'h30;
        cpu_wcyc = 1'b1;
        dbg_step = 1'b1;
        tick();
        dbg_step = 1'b0;
        cpu_advance();
        cpu_addr = 7'h79;
        cpu_advance();
        cpu_wcyc = 1'b0;
        cpu_addr = 7'h30;
        repeat (3) tick();
        host_xfer(1'b1, 7'h40, 4'hC);
        host_xfer(1'b0, 7'h7F, 4'h0);
        repeat (2) tick();
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 7'h01;
        dbg_step  = 1'b1;
        tick();
        dbg_step = 1'b0;
        wait_ack();
        host_req = 1'b0;
        repeat (3) tick();
        dbg_halt = 1'b0;
        repeat (4) tick();

        // Reset lands in the data phase of a CPU write.
        cpu_addr = 7'h33;
        cpu_wcyc = 1'b1;
        cpu_advance();
        cpu_addr = 7'h0F;
        rst_n    = 1'b0;
        repeat (2) tick();
        rst_n    = 1'b1;
        cpu_wcyc = 1'b0;
        cpu_addr = 7'h33;
        repeat (5) tick();

        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 7'h44;
        host_wdata = 4'h1;
        tick();
        rst_n    = 1'b0;
        host_req = 1'b0;
        repeat (2) tick();
        rst_n    = 1'b1;
        cpu_addr = 7'h44;
        repeat (4) tick();

        cpu_auto  = 1'b1;
        host_auto = 1'b1;
        dbg_auto  = 1'b1;
        repeat (4000) tick();

        dbg_auto  = 1'b0;
        dbg_halt  = 1'b0;
        dbg_step  = 1'b0;
        host_auto = 1'b0;
        if (host_req) wait_ack();
        host_req = 1'b0;
        for (int n = 0; n < 40 && cpu_ph != 0; n++) tick();
        cpu_auto = 1'b0;
        repeat (5) tick();
        done = 1'b1;
        repeat (10) @(posedge clk);
        $display("FAIL summary_not_reached: monitor did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/tt_cpu_mem_arbiter.md
Name: tt_cpu_mem_arbiter

Overview:
- Owns a 128x4 program/data RAM shared by the 4-bit accumulator CPU and a host loader/debug port.
- Decodes the CPU's multiplexed bus: a 7-bit address, plus a write strobe held high for an address phase and then a data phase.
- Freezes the CPU through a clock enable whenever the host owns the RAM or a debug halt is active.
- Guarantees the CPU a minimum number of cycles between host accesses, and never splits a CPU write.

Parameters:
- ADDR_W, 7, RAM address width; depth is 2**ADDR_W.
- DATA_W, 4, RAM word width.
- CPU_SLOTS, 2, CPU-enabled cycles guaranteed after each host access before the next host grant (0 = no holdoff).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_en  out  1  CPU clock enable; the CPU advances only on edges where cpu_en=1.
- cpu_addr  in  ADDR_W  CPU bus: address, or write data in bits [DATA_W-1:0] during the data phase.
- cpu_wcyc  in  1  CPU write strobe; high for the address phase and then the data phase.
- cpu_rdata  out  DATA_W  mem[cpu_addr], combinational read.
- host_req  in  1  host access request; held until host_ack.
- host_we  in  1  1=write, 0=read; stable while host_req is high.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_ack  out  1  one-cycle completion pulse, registered.
- host_rdata  out  DATA_W  read data, valid while host_ack=1 and held afterwards.
- dbg_halt  in  1  level request to halt the CPU.
- dbg_step  in  1  single-cycle pulse: advance a halted CPU by one step.
- halted  out  1  1 while state=HALT.

Behaviour:
- Reset (async, rst_n=0):
  - state=RUN, slot_cnt=0, waddr=0, host_ack=0, host_rdata=0.
  - RAM contents are not reset.
  - cpu_en=1 immediately after reset releases.
- cpu_en is combinational from state: 1 in RUN, WDATA and STEP; 0 in HOST and HALT.
- Host request eligibility: host_req=1 and host_ack=0. A request seen in the ack cycle is ignored.
- RUN:
  - cpu_wcyc=1: waddr<=cpu_addr, go to WDATA. This has priority over host and halt.
  - Else, eligible request and slot_cnt=0: go to HOST.
  - Else, dbg_halt=1: go to HALT. The CPU takes one more edge on the way out; this is accepted behaviour.
  - slot_cnt decrements, saturating at 0, in every RUN/WDATA/STEP cycle.
- WDATA:
  - mem[waddr]<=cpu_addr[DATA_W-1:0].
  - Next state is HALT if dbg_halt=1, else RUN.
  - A write always completes both phases; no host access or halt can land between them.
- HOST, one cycle:
  - Write: mem[host_addr]<=host_wdata. Read: host_rdata<=mem[host_addr].
  - host_ack<=1 for one cycle, slot_cnt<=CPU_SLOTS.
  - Next state is HALT if dbg_halt=1 or the HOST was entered from HALT, else RUN.
  - Request-to-ack latency is 2 cycles from RUN when slot_cnt=0.
- HALT:
  - An eligible host request goes to HOST, ignoring slot_cnt.
  - Else, dbg_step=1 goes to STEP.
  - Else, dbg_halt=0 goes to RUN.
  - Host has priority over step when both occur in the same cycle; the step pulse is then lost.
- STEP, one CPU edge:
  - cpu_wcyc=1: latch waddr, go to WDATA. The step consumes two edges and completes the write.
  - Else: HALT if dbg_halt=1, else RUN.
- Collisions:
  - The CPU RAM write (WDATA) and host RAM access (HOST) are mutually exclusive states, so no same-cycle port collision exists.
  - A host write to the address the CPU is reading changes cpu_rdata only while the CPU is frozen.
- Addresses wrap naturally at 2**ADDR_W. Bits above DATA_W-1 of cpu_addr are ignored in WDATA.
- Reset mid-operation:
  - A pending WDATA write is dropped and the RAM is unchanged.
  - A pending host_ack is cleared; the host must re-request.

Test Plan:
- Host writes 0x5 to addr 0x10 from RUN with slot_cnt=0 -> cpu_en=0 for exactly 1 cycle; host_ack pulses 2 cycles after req; a subsequent CPU read of 0x10 returns cpu_rdata=0x5.
- CPU bus drives addr 0x22 with wcyc=1, then 0x0A with wcyc=1, while host_req rises in the address cycle -> mem[0x22]=0xA; HOST entered only after WDATA; host_ack follows.
- Back-to-back host reads with CPU_SLOTS=2 -> at least 2 cpu_en=1 cycles between the two HOST cycles; host_rdata matches the preloaded values.
- dbg_halt=1 in RUN -> halted=1 one cycle later with cpu_en=0; each dbg_step pulse gives exactly one cpu_en=1 cycle, or two when the step hits a write address phase (write lands in RAM); dbg_halt=0 -> RUN.
- While halted, a host read of 0x7F is served with slot_cnt>0 -> host_ack pulses; state returns to HALT.
- rst_n pulled low during WDATA -> target word unchanged, host_ack=0, state=RUN, cpu_en=1 after release.
